// File: rtl/node_prog_loader.sv
// Converts a beat-serial stream of node records into PARENTS/CONFIG load packets.
// Optional saturating packet/node counters are enabled with `define PROG_LOADER_STATS_EN.
module node_prog_loader #(
  parameter int MESH_DIMENSION     = 4,
  parameter int NODES_PER_BANK     = 4,
  parameter int MAX_EDGES_PER_LOAD = 4,
  parameter int MAX_EDGES_IOO      = 8,
  parameter int NODE_ID_W          = 8,
  parameter int CHILD_W            = 8,
  localparam int NP_W = $clog2(MAX_EDGES_IOO + 1),
  localparam int XY_W = $clog2(MESH_DIMENSION),
  localparam int Z_W  = $clog2(NODES_PER_BANK),
  localparam int NE_W = $clog2(MAX_EDGES_PER_LOAD + 1),
  localparam int ED_W = MAX_EDGES_PER_LOAD * NODE_ID_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_hdr,
  input  logic                 in_last,
  input  logic [NODE_ID_W-1:0] in_node_id,
  input  logic [NP_W-1:0]      in_num_parents,
  input  logic [CHILD_W-1:0]   in_num_children,
  input  logic                 in_is_you,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_is_config,
  output logic [XY_W-1:0]      out_x,
  output logic [XY_W-1:0]      out_y,
  output logic [Z_W-1:0]       out_z,
  output logic [NE_W-1:0]      out_num_edges,
  output logic [ED_W-1:0]      out_edges,
  output logic                 out_is_you,
  output logic [CHILD_W-1:0]   out_num_children,
  output logic                 load_done,
  output logic                 err,
`ifdef PROG_LOADER_STATS_EN
  output logic [15:0]          pkt_count,
  output logic [NODE_ID_W:0]   node_count,
`endif
  output logic [2:0]           dbg_state
);

  // valid/ready: a beat or packet transfers on a rising edge where valid && ready;
  // out_valid holds with stable payload until that transfer.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PARENTS  = 3'd1,
    ST_SEND_PAR = 3'd2,
    ST_SEND_CFG = 3'd3,
    ST_DROP     = 3'd4
  } state_t;

  state_t               r_state;
  logic [XY_W-1:0]      r_x;
  logic [XY_W-1:0]      r_y;
  logic [Z_W-1:0]       r_z;
  logic                 r_is_you;
  logic                 r_last;
  logic [CHILD_W-1:0]   r_children;
  logic [NP_W-1:0]      r_rem;
  logic [NE_W-1:0]      r_cnt;
  logic [ED_W-1:0]      r_slots;

  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_id_ok;
  logic [XY_W-1:0]      w_x;
  logic [XY_W-1:0]      w_y;
  logic [Z_W-1:0]       w_z;
  logic [NE_W-1:0]      w_cnt_inc;
  logic [NP_W-1:0]      w_rem_dec;
  logic                 w_launch;
  logic [ED_W-1:0]      w_slots;

  assign dbg_state  = r_state;
  assign in_ready   = rst && (r_state == ST_IDLE || r_state == ST_PARENTS || r_state == ST_DROP);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Node id is {x, y, z}; anything above those bits is outside the mesh.
  assign w_z       = in_node_id[Z_W-1:0];
  assign w_y       = in_node_id[Z_W +: XY_W];
  assign w_x       = XY_W'(in_node_id >> (Z_W + XY_W));
  assign w_id_ok   = (in_node_id >> (2 * XY_W + Z_W)) == '0;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_rem_dec = r_rem - 1'b1;
  assign w_launch  = (w_cnt_inc == NE_W'(MAX_EDGES_PER_LOAD)) || (w_rem_dec == '0);

  always_comb begin
    w_slots = r_slots;
    for (int i = 0; i < MAX_EDGES_PER_LOAD; i++) begin
      if (r_cnt == NE_W'(i)) w_slots[i*NODE_ID_W +: NODE_ID_W] = in_node_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_IDLE;
      r_x              <= '0;
      r_y              <= '0;
      r_z              <= '0;
      r_is_you         <= 1'b0;
      r_last           <= 1'b0;
      r_children       <= '0;
      r_rem            <= '0;
      r_cnt            <= '0;
      r_slots          <= '0;
      out_valid        <= 1'b0;
      out_is_config    <= 1'b0;
      out_x            <= '0;
      out_y            <= '0;
      out_z            <= '0;
      out_num_edges    <= '0;
      out_edges        <= '0;
      out_is_you       <= 1'b0;
      out_num_children <= '0;
      load_done        <= 1'b0;
      err              <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            if (!in_hdr) begin
              err <= 1'b1;
            end else if (!w_id_ok) begin
              err   <= 1'b1;
              r_rem <= in_num_parents;
              if (in_num_parents != '0) r_state <= ST_DROP;
            end else begin
              r_x        <= w_x;
              r_y        <= w_y;
              r_z        <= w_z;
              r_is_you   <= in_is_you;
              r_last     <= in_last;
              r_children <= in_num_children;
              r_rem      <= in_num_parents;
              r_cnt      <= '0;
              r_slots    <= '0;
              if (in_num_parents != '0) begin
                r_state <= ST_PARENTS;
              end else begin
                r_state          <= ST_SEND_CFG;
                out_valid        <= 1'b1;
                out_is_config    <= 1'b1;
                out_x            <= w_x;
                out_y            <= w_y;
                out_z            <= w_z;
                out_num_edges    <= '0;
                out_edges        <= '0;
                out_is_you       <= in_is_you;
                out_num_children <= in_num_children;
              end
            end
          end
        end
        ST_PARENTS: begin
          if (w_in_fire) begin
            if (in_hdr) begin
              err <= 1'b1;
            end else begin
              r_slots <= w_slots;
              r_cnt   <= w_cnt_inc;
              r_rem   <= w_rem_dec;
              if (w_launch) begin
                r_state          <= ST_SEND_PAR;
                out_valid        <= 1'b1;
                out_is_config    <= 1'b0;
                out_x            <= r_x;
                out_y            <= r_y;
                out_z            <= r_z;
                out_num_edges    <= w_cnt_inc;
                out_edges        <= w_slots;
                out_is_you       <= 1'b0;
                out_num_children <= '0;
              end
            end
          end
        end
        ST_SEND_PAR: begin
          if (w_out_fire) begin
            r_cnt   <= '0;
            r_slots <= '0;
            if (r_rem != '0) begin
              r_state   <= ST_PARENTS;
              out_valid <= 1'b0;
            end else begin
              // Straight into CONFIG: out_valid stays high with the new payload.
              r_state          <= ST_SEND_CFG;
              out_is_config    <= 1'b1;
              out_num_edges    <= '0;
              out_edges        <= '0;
              out_is_you       <= r_is_you;
              out_num_children <= r_children;
            end
          end
        end
        ST_SEND_CFG: begin
          if (w_out_fire) begin
            out_valid <= 1'b0;
            r_state   <= ST_IDLE;
            if (r_last) load_done <= 1'b1;
          end
        end
        ST_DROP: begin
          if (w_in_fire) begin
            if (in_hdr) begin
              err <= 1'b1;
            end else begin
              r_rem <= w_rem_dec;
              if (w_rem_dec == '0) r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PROG_LOADER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count  <= '0;
      node_count <= '0;
    end else begin
      if (w_out_fire && pkt_count != '1) pkt_count <= pkt_count + 1'b1;
      if (w_out_fire && out_is_config && node_count != '1) node_count <= node_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_node_prog_loader.sv
// Bench for node_prog_loader: vector table, hand-written corner sequences and
// randomized records scored against a packet-level reference model.
module tb_node_prog_loader;
  localparam int PW = 51;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_hdr = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  in_node_id = '0;
  logic [3:0]  in_num_parents = '0;
  logic [7:0]  in_num_children = '0;
  logic        in_is_you = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_is_config;
  logic [1:0]  out_x, out_y, out_z;
  logic [2:0]  out_num_edges;
  logic [31:0] out_edges;
  logic        out_is_you;
  logic [7:0]  out_num_children;
  logic        load_done;
  logic        err;
  logic [2:0]  dbg_state;
`ifdef PROG_LOADER_STATS_EN
  logic [15:0] pkt_count;
  logic [8:0]  node_count;
`endif

  node_prog_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_hdr(in_hdr), .in_last(in_last),
    .in_node_id(in_node_id), .in_num_parents(in_num_parents),
    .in_num_children(in_num_children), .in_is_you(in_is_you),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_config(out_is_config),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_num_edges(out_num_edges),
    .out_edges(out_edges), .out_is_you(out_is_you), .out_num_children(out_num_children),
    .load_done(load_done), .err(err),
`ifdef PROG_LOADER_STATS_EN
    .pkt_count(pkt_count), .node_count(node_count),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] exp_q[$];
  logic exp_err = 1'b0;
  logic exp_done = 1'b0;
  int ready_mode = 0;
  int pkt_seen = 0;
  int cfg_x, cfg_y, cfg_z;

  // CONFIG-only fields are masked on PARENTS packets.
  logic [PW-1:0] w_act;
  logic [53:0]   w_all_outs;
  assign w_act = {out_is_config, out_x, out_y, out_z, out_num_edges, out_edges,
                  out_is_config ? out_is_you : 1'b0, out_is_config ? out_num_children : 8'd0};
  assign w_all_outs = {out_valid, out_is_config, out_x, out_y, out_z, out_num_edges, out_edges,
                       out_is_you, out_num_children, load_done, err};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pack_pkt(input logic cfg, input int id, input int ne,
                                              input logic [31:0] ed, input logic iy, input int ch);
    return {cfg, 2'(id / 16), 2'((id / 4) % 4), 2'(id % 4), 3'(ne), ed, iy, 8'(ch)};
  endfunction

  // Output side: drives out_ready and scores every accepted packet.
  logic [PW-1:0] prev_pkt;
  logic prev_pending = 1'b0;
  int stall_cnt = 0;
  always @(negedge clk) begin
    logic rdy;
    logic [PW-1:0] e;
    if (!rst) begin
      prev_pending = 1'b0;
      stall_cnt = 0;
      out_ready = 1'b0;
    end else begin
      case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 2) != 0);
        2: rdy = 1'b0;
        default: rdy = (stall_cnt >= 5);
      endcase
      out_ready = rdy;
      if (out_valid) begin
        chk("in_ready_while_valid", in_ready, 0);
        if (prev_pending) chk("hold_stable", w_act, prev_pkt);
        if (rdy) begin
          pkt_seen++;
          if (out_is_config) begin
            cfg_x = out_x; cfg_y = out_y; cfg_z = out_z;
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_pkt", w_act, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pkt", w_act, e);
          end
          prev_pending = 1'b0;
          stall_cnt = 0;
        end else begin
          prev_pending = 1'b1;
          prev_pkt = w_act;
          stall_cnt++;
        end
      end else begin
        if (prev_pending) chk("valid_withdrawn", out_valid, 1);
        prev_pending = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  task automatic send_beat(input logic hdr, input logic last, input int id, input int np,
                           input int ch, input logic iy);
    int w = 0;
    @(negedge clk);
    in_hdr = hdr; in_last = last; in_node_id = 8'(id); in_num_parents = 4'(np);
    in_num_children = 8'(ch); in_is_you = iy; in_valid = 1'b1;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      chk("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_record(input int id, input int np, input int ch, input logic iy,
                             input logic last, input logic rnd);
    logic [7:0] par[8];
    logic [31:0] ed;
    int n;
    logic ok;
    ok = (id < 64);
    for (int j = 0; j < np; j++) par[j] = rnd ? 8'($urandom_range(0, 255)) : 8'(10 + j);
    if (ok) begin
      for (int k = 0; k < np; k += 4) begin
        n = (np - k < 4) ? np - k : 4;
        ed = '0;
        for (int j = 0; j < n; j++) ed[j*8 +: 8] = par[k+j];
        exp_q.push_back(pack_pkt(1'b0, id, n, ed, 1'b0, 0));
      end
      exp_q.push_back(pack_pkt(1'b1, id, 0, 32'd0, iy, ch));
      if (last) exp_done = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
    send_beat(1'b1, last, id, np, ch, iy);
    chk("err_after_hdr", err, exp_err);
    chk("hdr_latency", out_valid, ok && np == 0);
    for (int j = 0; j < np; j++) begin
      send_beat(1'b0, 1'b0, par[j], 0, 0, 1'b0);
      chk("par_latency", out_valid, ok && ((j + 1) % 4 == 0 || j + 1 == np));
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 1000) begin
      @(posedge clk);
      w++;
    end
    if (w >= 1000) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int id; int np; int ch; logic iy;
    int pkts; int ex; int ey; int ez; logic e_err;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int base;
    int w;
    tbl[0] = '{37, 0, 2,   1'b0, 1, 2, 1, 1, 1'b0};
    tbl[1] = '{5,  6, 3,   1'b1, 3, 0, 1, 1, 1'b0};
    tbl[2] = '{63, 4, 0,   1'b0, 2, 3, 3, 3, 1'b0};
    tbl[3] = '{0,  8, 255, 1'b1, 3, 0, 0, 0, 1'b0};
    tbl[4] = '{22, 5, 7,   1'b0, 3, 1, 1, 2, 1'b0};
    tbl[5] = '{70, 2, 9,   1'b0, 0, 0, 0, 0, 1'b1};
    tbl[6] = '{64, 0, 9,   1'b1, 0, 0, 0, 0, 1'b1};
    tbl[7] = '{48, 1, 1,   1'b1, 2, 3, 0, 0, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outs", w_all_outs, 0);
    chk("reset_in_ready", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_state", dbg_state, 0);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      base = pkt_seen;
      send_record(tbl[i].id, tbl[i].np, tbl[i].ch, tbl[i].iy, 1'b0, 1'b0);
      drain();
      chk("tbl_pkts", pkt_seen - base, tbl[i].pkts);
      if (tbl[i].pkts > 0) begin
        chk("tbl_x", cfg_x, tbl[i].ex);
        chk("tbl_y", cfg_y, tbl[i].ey);
        chk("tbl_z", cfg_z, tbl[i].ez);
      end
      chk("tbl_err", err, tbl[i].e_err);
    end

    // Five-cycle stall on every packet
    ready_mode = 3;
    base = pkt_seen;
    send_record(5, 6, 3, 1'b1, 1'b0, 1'b0);
    drain();
    chk("stall_pkts", pkt_seen - base, 3);
    ready_mode = 0;

    // load_done timing and stickiness
    chk("done_initial", load_done, 0);
    send_record(0, 1, 4, 1'b1, 1'b1, 1'b0);
    w = 0;
    do begin
      @(posedge clk);
      #2;
      w++;
    end while (!(out_valid && out_is_config) && w < 50);
    chk("cfg_seen", out_valid && out_is_config, 1);
    chk("done_before_hs", load_done, 0);
    @(posedge clk);
    #1;
    chk("done_after_hs", load_done, 1);
    drain();
    base = pkt_seen;
    send_record(21, 3, 6, 1'b0, 1'b0, 1'b0);
    drain();
    chk("after_done_pkts", pkt_seen - base, 2);
    chk("done_sticky", load_done, 1);

    // Stray parent beat in IDLE, then reset in the middle of a record
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_clears_err", err, 0);
    send_beat(1'b0, 1'b0, 3, 0, 0, 1'b0);
    chk("idle_parent_err", err, 1);
    send_beat(1'b1, 1'b0, 9, 3, 1, 1'b0);
    send_beat(1'b0, 1'b0, 40, 0, 0, 1'b0);
    send_beat(1'b0, 1'b0, 41, 0, 0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midrec_reset_outs", w_all_outs, 0);
    chk("midrec_reset_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_state", dbg_state, 0);
    chk("post_reset_in_ready", in_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_outs", w_all_outs, 0);

    // Randomized back-to-back records
    for (int r = 0; r < 40; r++) begin
      ready_mode = $urandom_range(0, 3);
      if (ready_mode == 2) ready_mode = 1;
      send_record($urandom_range(0, 79), $urandom_range(0, 8), $urandom_range(0, 255),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 1'b1);
    end
    ready_mode = 0;
    drain();
    chk("rand_err", err, exp_err);
    chk("rand_done", load_done, exp_done);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
